// File: rtl/vga_pkg.sv
// Shared timing defaults, counter width, total-period helpers and FSM encoding
// for the VGA scan controller.
package vga_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned HFpDef     = 16;
  localparam int unsigned HSyncDef   = 96;
  localparam int unsigned HBpDef     = 48;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned VFpDef     = 10;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBpDef     = 33;

  localparam int unsigned CntW = 12;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } vc_state_e;

  function automatic int unsigned h_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical scan counters; held at zero while not running, wrap at
// the end of each line and frame.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned HTotal = 800,
  parameter int unsigned VTotal = 525
) (
  input  logic            clk_v,
  input  logic            resetn,
  input  logic            run_i,
  output logic [CntW-1:0] h_cnt_o,
  output logic [CntW-1:0] v_cnt_o,
  output logic            eof_o
);

  localparam logic [CntW-1:0] HMax   = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VMax   = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] h_cnt_q, h_cnt_d;
  logic [CntW-1:0] v_cnt_q, v_cnt_d;
  logic            h_last, v_last;

  assign h_last = (h_cnt_q == HMax);
  assign v_last = (v_cnt_q == VMax);

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!run_i) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = v_last ? '0 : v_cnt_q + CntOne;
    end else begin
      h_cnt_d = h_cnt_q + CntOne;
    end
  end

  always_ff @(posedge clk_v) begin
    if (!resetn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o = h_cnt_q;
  assign v_cnt_o = v_cnt_q;
  assign eof_o   = h_last & v_last;

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: run/idle FSM, pixel request gating with per-frame
// underflow blanking, and a two-stage registered path to the RGB/sync pins.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned H_FP     = HFpDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BP     = HBpDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FP     = VFpDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BP     = VBpDef,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic        clk_v,
  input  logic        resetn,
  input  logic        en_i,
  input  logic        buf_ready_i,
  input  logic [11:0] pix_data_i,
  input  logic        underflow_clr_i,
  output logic        data_req_o,
  output logic        frame_start_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic [11:0] rgb_o,
  output logic        underflow_o
);

  localparam int unsigned HTotal = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CntW-1:0] HAct   = CntW'(H_ACTIVE);
  localparam logic [CntW-1:0] HSyncS = CntW'(H_ACTIVE + H_FP);
  localparam logic [CntW-1:0] HSyncE = CntW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CntW-1:0] VAct   = CntW'(V_ACTIVE);
  localparam logic [CntW-1:0] VSyncS = CntW'(V_ACTIVE + V_FP);
  localparam logic [CntW-1:0] VSyncE = CntW'(V_ACTIVE + V_FP + V_SYNC);

  vc_state_e       state_q, state_d;
  logic            run;
  logic [CntW-1:0] h_cnt, v_cnt;
  logic            eof;

  logic frame_top, active, blank_cur, hs, vs;
  logic blank_q, blank_d;
  logic underflow_q, underflow_d;
  logic frame_start_q, frame_start_d;
  logic de_q, hs_q, vs_q;
  logic [11:0] rgb_q;
  logic hsync_q, vsync_q;

  assign run = (state_q == StRun);

  vga_sync_counter #(
    .HTotal (HTotal),
    .VTotal (VTotal)
  ) u_cnt (
    .clk_v   (clk_v),
    .resetn  (resetn),
    .run_i   (run),
    .h_cnt_o (h_cnt),
    .v_cnt_o (v_cnt),
    .eof_o   (eof)
  );

  assign frame_top = run && (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < HAct) && (v_cnt < VAct);
  // The frame-start decision must gate the very first request of the frame.
  assign blank_cur = frame_top ? ~buf_ready_i : blank_q;

  always_comb begin
    state_d       = state_q;
    blank_d       = blank_cur;
    frame_start_d = frame_top;
    underflow_d   = underflow_q;
    data_req_o    = 1'b0;
    hs            = 1'b0;
    vs            = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en_i) state_d = StRun;
      end
      StRun: begin
        if (eof && !en_i) state_d = StIdle;
        data_req_o = active && !blank_cur;
        hs         = (h_cnt >= HSyncS) && (h_cnt < HSyncE);
        vs         = (v_cnt >= VSyncS) && (v_cnt < VSyncE);
      end
      default: state_d = StIdle;
    endcase

    // A new underflow wins over a clear arriving on the same cycle.
    if (frame_top && !buf_ready_i) begin
      underflow_d = 1'b1;
    end else if (underflow_clr_i) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_v) begin
    if (!resetn) begin
      state_q       <= StIdle;
      blank_q       <= 1'b0;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
      de_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      rgb_q         <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
    end else begin
      state_q       <= state_d;
      blank_q       <= blank_d;
      underflow_q   <= underflow_d;
      frame_start_q <= frame_start_d;
      de_q          <= data_req_o;
      hs_q          <= hs;
      vs_q          <= vs;
      // Buffer data arrives one cycle after the request, in step with de_q.
      rgb_q         <= de_q ? pix_data_i : 12'h000;
      hsync_q       <= hs_q ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= vs_q ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign frame_start_o = frame_start_q;
  assign underflow_o   = underflow_q;
  assign rgb_o         = rgb_q;
  assign hsync_o       = hsync_q;
  assign vsync_o       = vsync_q;

endmodule
